// File: rtl/width_packer.sv
`default_nettype none
// ============================================================================
// Module      : width_packer
// Description : Narrow-to-wide gearbox. Packs OW/IW consecutive IW-bit beats
//               into one OW-bit word, first beat in the most-significant lane.
//               ilast closes a frame early; okeep flags the valid lanes.
//               Optional macro WIDTH_PACKER_CNT_EN adds a 32-bit ocount port
//               counting output transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module width_packer #(
    parameter int IW = 32,
    parameter int OW = 64
) (
    input  logic             clk,
    input  logic             rst,      // asynchronous, active-low
    input  logic [IW-1:0]    idata,
    input  logic             ivalid,
    input  logic             ilast,
    output logic             iready,
    output logic [OW-1:0]    odata,
    output logic [OW/IW-1:0] okeep,
    output logic             olast,
    output logic             ovalid,
`ifdef WIDTH_PACKER_CNT_EN
    output logic [31:0]      ocount,
`endif
    input  logic             oready
);

    localparam int RATIO = OW / IW;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] c_last_lane = CW'(RATIO - 1);

    // Reject geometries that cannot be packed lane-for-lane.
    if ((OW % IW) != 0 || RATIO < 2) begin : g_bad_cfg
        $error("width_packer: OW must be an integer multiple of IW with OW/IW >= 2");
    end

    logic [CW-1:0]    r_cnt;
    logic [OW-1:0]    r_acc;
    logic [OW-1:0]    r_odata;
    logic [RATIO-1:0] r_okeep;
    logic             r_olast;
    logic             r_ovalid;

    logic             w_completing;
    logic             w_out_free;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [OW-1:0]    w_word;
    logic [RATIO-1:0] w_keep;

    // A beat closes the word on the last lane or on an explicit frame end;
    // only such beats need room in the output register.
    assign w_completing = (r_cnt == c_last_lane) || ilast;
    assign w_out_free   = !r_ovalid || oready;
    assign iready       = w_completing ? w_out_free : 1'b1;
    assign w_in_xfer    = ivalid && iready;
    assign w_out_xfer   = r_ovalid && oready;

    // Accumulated lanes plus the incoming beat in lane cnt; later lanes zero.
    always_comb begin
        w_word = '0;
        w_keep = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (i == int'(r_cnt)) begin
                w_word[OW-1-i*IW -: IW] = idata;
                w_keep[RATIO-1-i]       = 1'b1;
            end else if (i < int'(r_cnt)) begin
                w_word[OW-1-i*IW -: IW] = r_acc[OW-1-i*IW -: IW];
                w_keep[RATIO-1-i]       = 1'b1;
            end
        end
    end

    // Lane counter and accumulator; cleared whenever a word is handed off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_in_xfer) begin
            if (w_completing) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= w_word;
            end
        end
    end

    // Output register: a completing beat overwrites it in the same cycle the
    // previous word drains, so back-to-back words have no bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_odata  <= '0;
            r_okeep  <= '0;
            r_olast  <= 1'b0;
            r_ovalid <= 1'b0;
        end else if (w_in_xfer && w_completing) begin
            r_odata  <= w_word;
            r_okeep  <= w_keep;
            r_olast  <= ilast;
            r_ovalid <= 1'b1;
        end else if (w_out_xfer) begin
            r_ovalid <= 1'b0;
        end
    end

    assign odata  = r_odata;
    assign okeep  = r_okeep;
    assign olast  = r_olast;
    assign ovalid = r_ovalid;

`ifdef WIDTH_PACKER_CNT_EN
    logic [31:0] r_ocount;

    // Free-running count of delivered words, wrapping naturally at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ocount <= '0;
        end else if (w_out_xfer) begin
            r_ocount <= r_ocount + 32'd1;
        end
    end

    assign ocount = r_ocount;
`endif

endmodule
`default_nettype wire
